// File: rtl/exe_wb_arbiter.sv
// exe_wb_arbiter
// Shares the single execute-to-writeback result port between the execute
// units (0 = ALU/branch, 1 = MUL, 2 = DIV, 3 = MEM). Each source owns a
// one-entry holding buffer. A round-robin arbiter drains the full buffers
// into writeback and honours backpressure from writeback.
//
// Ports:
//   clk_i, rstn_i      clock; asynchronous active-low reset
//   kill_i             pipeline flush, empties every buffer at the next edge
//   src_valid_i        per-source result valid (done tick)
//   src_rd_i           per-source destination register, source i at [i*RD_W +: RD_W]
//   src_data_i         per-source result, source i at [i*DATA_W +: DATA_W]
//   src_ready_o        per-source accept
//   wb_valid_o         a result is presented to writeback
//   wb_rd_o            destination register of the presented result
//   wb_data_o          presented result
//   wb_src_o           index of the granted source
//   wb_ready_i         writeback accepts this cycle
//   busy_o             at least one buffer is full
//   conflict_cnt_o     saturating count of cycles with two or more buffers full
//
// Optional feature (macro EXE_WB_BYPASS_EN): when every buffer is empty, the
// lowest-index valid source with rd != 0 is forwarded combinationally to the
// writeback port. It completes without being buffered if wb_ready_i is high,
// otherwise it is captured as usual. Without the macro, results are always
// buffered and reach writeback one cycle after acceptance at the earliest.

module exe_wb_arbiter #(
    parameter int NUM_SRC = 4,
    parameter int DATA_W  = 64,
    parameter int RD_W    = 5,
    parameter int CNT_W   = 16,
    localparam int SRC_W  = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
    input  logic                      clk_i,
    input  logic                      rstn_i,
    input  logic                      kill_i,
    input  logic [NUM_SRC-1:0]        src_valid_i,
    input  logic [NUM_SRC*RD_W-1:0]   src_rd_i,
    input  logic [NUM_SRC*DATA_W-1:0] src_data_i,
    output logic [NUM_SRC-1:0]        src_ready_o,
    output logic                      wb_valid_o,
    output logic [RD_W-1:0]           wb_rd_o,
    output logic [DATA_W-1:0]         wb_data_o,
    output logic [SRC_W-1:0]          wb_src_o,
    input  logic                      wb_ready_i,
    output logic                      busy_o,
    output logic [CNT_W-1:0]          conflict_cnt_o
);

    // Buffer state
    logic [NUM_SRC-1:0] full_reg;
    logic [NUM_SRC-1:0] full_next;
    logic [RD_W-1:0]    rd_reg   [NUM_SRC];
    logic [DATA_W-1:0]  data_reg [NUM_SRC];

    // Arbitration state. hold_reg freezes the grant while writeback stalls,
    // so a buffer that fills during the stall cannot steal the port.
    logic [SRC_W-1:0]   ptr_reg;
    logic               hold_reg;
    logic [SRC_W-1:0]   hold_idx_reg;
    logic [CNT_W-1:0]   cnt_reg;

    logic               grant_valid;
    logic [SRC_W-1:0]   grant_idx;
    logic [SRC_W-1:0]   cand_idx;

    logic               byp_valid;
    logic [SRC_W-1:0]   byp_idx;

    logic [RD_W-1:0]    in_rd   [NUM_SRC];
    logic [DATA_W-1:0]  in_data [NUM_SRC];
    logic [NUM_SRC-1:0] take;
    logic [NUM_SRC-1:0] capture;
    logic [NUM_SRC-1:0] bypass_done;

    // Round-robin search starting just after the last granted index.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        cand_idx    = '0;
        if (hold_reg) begin
            grant_valid = full_reg[hold_idx_reg];
            grant_idx   = hold_idx_reg;
        end else begin
            for (int k = 1; k <= NUM_SRC; k++) begin
                cand_idx = SRC_W'((int'(ptr_reg) + k) % NUM_SRC);
                if (!grant_valid && full_reg[cand_idx]) begin
                    grant_valid = 1'b1;
                    grant_idx   = cand_idx;
                end
            end
        end
    end

`ifdef EXE_WB_BYPASS_EN
    // Forward the lowest-index valid source when nothing is buffered.
    always_comb begin
        byp_valid = 1'b0;
        byp_idx   = '0;
        if (!(|full_reg) && !kill_i) begin
            for (int i = NUM_SRC - 1; i >= 0; i--) begin
                if (src_valid_i[i] && (in_rd[i] != '0)) begin
                    byp_valid = 1'b1;
                    byp_idx   = SRC_W'(i);
                end
            end
        end
    end
`else
    assign byp_valid = 1'b0;
    assign byp_idx   = '0;
`endif

    // Per-source handshake and buffer next-state.
    generate
        for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
            assign in_rd[gi]       = src_rd_i[gi*RD_W +: RD_W];
            assign in_data[gi]     = src_data_i[gi*DATA_W +: DATA_W];
            assign take[gi]        = grant_valid && (grant_idx == SRC_W'(gi)) && wb_ready_i;
            assign bypass_done[gi] = byp_valid && (byp_idx == SRC_W'(gi)) && wb_ready_i;
            assign src_ready_o[gi] = !kill_i && (!full_reg[gi] || take[gi]);
            // rd == 0 results are accepted but never stored.
            assign capture[gi]     = src_valid_i[gi] && src_ready_o[gi]
                                     && (in_rd[gi] != '0) && !bypass_done[gi];
            assign full_next[gi]   = kill_i      ? 1'b0 :
                                     capture[gi] ? 1'b1 :
                                     take[gi]    ? 1'b0 : full_reg[gi];
        end
    endgenerate

    // Writeback port mux; all fields are zero when nothing is presented.
    always_comb begin
        wb_valid_o = grant_valid || byp_valid;
        wb_src_o   = '0;
        wb_rd_o    = '0;
        wb_data_o  = '0;
        if (grant_valid) begin
            wb_src_o  = grant_idx;
            wb_rd_o   = rd_reg[grant_idx];
            wb_data_o = data_reg[grant_idx];
        end else if (byp_valid) begin
            wb_src_o  = byp_idx;
            wb_rd_o   = in_rd[byp_idx];
            wb_data_o = in_data[byp_idx];
        end
    end

    assign busy_o         = |full_reg;
    assign conflict_cnt_o = cnt_reg;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            full_reg     <= '0;
            ptr_reg      <= SRC_W'(NUM_SRC - 1);
            hold_reg     <= 1'b0;
            hold_idx_reg <= '0;
            cnt_reg      <= '0;
            for (int i = 0; i < NUM_SRC; i++) begin
                rd_reg[i]   <= '0;
                data_reg[i] <= '0;
            end
        end else begin
            full_reg <= full_next;
            for (int i = 0; i < NUM_SRC; i++) begin
                if (capture[i]) begin
                    rd_reg[i]   <= in_rd[i];
                    data_reg[i] <= in_data[i];
                end
            end
            if (kill_i) begin
                hold_reg <= 1'b0;
            end else begin
                hold_reg     <= grant_valid && !wb_ready_i;
                hold_idx_reg <= grant_idx;
            end
            // A transfer in the kill cycle is discarded by writeback, so the
            // pointer only advances on transfers outside a flush.
            if (!kill_i && wb_valid_o && wb_ready_i) begin
                ptr_reg <= wb_src_o;
            end
            if (($countones(full_reg) >= 2) && (cnt_reg != {CNT_W{1'b1}})) begin
                cnt_reg <= cnt_reg + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_exe_wb_arbiter.sv
// Directed testbench for exe_wb_arbiter (default build, no bypass).
// A queue-free behavioural model tracks which sources hold a result, the
// round-robin pointer and the stall lock; a compare process checks every DUT
// output against it on each falling clock edge. Directed scenarios add
// literal expectations that pin the model.

module tb_exe_wb_arbiter;

    localparam int N  = 4;
    localparam int DW = 64;
    localparam int RW = 5;
    localparam int CW = 16;
    localparam int SW = 2;

    logic            clk = 1'b0;
    logic            rstn = 1'b0;
    logic            kill = 1'b0;
    logic            wb_ready = 1'b0;
    logic [N-1:0]    src_valid = '0;
    logic [N*RW-1:0] src_rd = '0;
    logic [N*DW-1:0] src_data = '0;
    logic [N-1:0]    src_ready;
    logic            wb_valid;
    logic [RW-1:0]   wb_rd;
    logic [DW-1:0]   wb_data;
    logic [SW-1:0]   wb_src;
    logic            busy;
    logic [CW-1:0]   conflict_cnt;

    exe_wb_arbiter #(.NUM_SRC(N), .DATA_W(DW), .RD_W(RW), .CNT_W(CW)) dut (
        .clk_i          (clk),
        .rstn_i         (rstn),
        .kill_i         (kill),
        .src_valid_i    (src_valid),
        .src_rd_i       (src_rd),
        .src_data_i     (src_data),
        .src_ready_o    (src_ready),
        .wb_valid_o     (wb_valid),
        .wb_rd_o        (wb_rd),
        .wb_data_o      (wb_data),
        .wb_src_o       (wb_src),
        .wb_ready_i     (wb_ready),
        .busy_o         (busy),
        .conflict_cnt_o (conflict_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endfunction

    // ---------------- behavioural model ----------------
    bit          m_full [N] = '{default: 1'b0};
    int          m_rd   [N] = '{default: 0};
    logic [63:0] m_data [N] = '{default: 64'd0};
    int          m_ptr  = N - 1;
    int          m_lock = -1;   // source frozen on the port during a stall
    int          m_cnt  = 0;

    function automatic int in_rd(int i);
        return int'(src_rd[i*RW +: RW]);
    endfunction

    function automatic logic [63:0] in_data(int i);
        return src_data[i*DW +: DW];
    endfunction

    // Index presented to writeback, or -1 if none.
    function automatic int m_pick();
        if (m_lock >= 0) return m_lock;
        for (int k = 1; k <= N; k++) begin
            if (m_full[(m_ptr + k) % N]) return (m_ptr + k) % N;
        end
        return -1;
    endfunction

    initial begin : model
        forever begin
            @(posedge clk or negedge rstn);
            if (!rstn) begin
                for (int i = 0; i < N; i++) m_full[i] = 1'b0;
                m_ptr  = N - 1;
                m_lock = -1;
                m_cnt  = 0;
            end else begin
                int p;
                int nfull;
                p = m_pick();
                nfull = 0;
                for (int i = 0; i < N; i++) if (m_full[i]) nfull++;
                if (nfull >= 2 && m_cnt < 65535) m_cnt = m_cnt + 1;
                if (kill) begin
                    for (int i = 0; i < N; i++) m_full[i] = 1'b0;
                    m_lock = -1;
                end else begin
                    for (int i = 0; i < N; i++) begin
                        bit tk;
                        tk = (p == i) && wb_ready;
                        if (src_valid[i] && (!m_full[i] || tk) && in_rd(i) != 0) begin
                            m_full[i] = 1'b1;
                            m_rd[i]   = in_rd(i);
                            m_data[i] = in_data(i);
                        end else if (tk) begin
                            m_full[i] = 1'b0;
                        end
                    end
                    m_lock = (p >= 0 && !wb_ready) ? p : -1;
                    if (p >= 0 && wb_ready) m_ptr = p;
                end
            end
        end
    end

    initial begin : compare
        forever begin
            @(negedge clk);
            if (cmp_en) begin
                int p;
                logic [N-1:0] erdy;
                bit ebusy;
                p = m_pick();
                ebusy = 1'b0;
                for (int i = 0; i < N; i++) begin
                    erdy[i] = !kill && (!m_full[i] || (p == i && wb_ready));
                    if (m_full[i]) ebusy = 1'b1;
                end
                chk("cyc_wb_valid", 64'(wb_valid), 64'(p >= 0));
                chk("cyc_wb_rd",    64'(wb_rd),    (p >= 0) ? 64'(m_rd[p]) : 64'd0);
                chk("cyc_wb_data",  wb_data,       (p >= 0) ? m_data[p] : 64'd0);
                chk("cyc_wb_src",   64'(wb_src),   (p >= 0) ? 64'(p) : 64'd0);
                chk("cyc_ready",    64'(src_ready), 64'(erdy));
                chk("cyc_busy",     64'(busy),     64'(ebusy));
                chk("cyc_cnt",      64'(conflict_cnt), 64'(m_cnt));
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic drive(int i, int rd, logic [63:0] d);
        logic [RW-1:0] r;
        r = RW'(rd);
        src_valid[i]         = 1'b1;
        src_rd[i*RW +: RW]   = r;
        src_data[i*DW +: DW] = d;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        tick();
        tick();
        rstn = 1'b1;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "timeout");
    end

    initial begin : stim
        int tp_cnt;
        logic [N-1:0] acc;
        logic [63:0] tp_data [N];

        do_reset();
        cmp_en = 1'b1;
        settle();
        $display("txn reset: checking reset values");
        chk("rst_wb_valid", 64'(wb_valid), 64'd0);
        chk("rst_busy",     64'(busy), 64'd0);
        chk("rst_ready",    64'(src_ready), 64'hF);
        chk("rst_cnt",      64'(conflict_cnt), 64'd0);

        // Single source
        wb_ready = 1'b1;
        drive(1, 7, 64'h1234);
        tick();
        src_valid = '0;
        settle();
        $display("txn single: MUL rd=7 data=1234");
        chk("single_valid", 64'(wb_valid), 64'd1);
        chk("single_src",   64'(wb_src), 64'd1);
        chk("single_rd",    64'(wb_rd), 64'd7);
        chk("single_data",  wb_data, 64'h1234);
        tick();
        settle();
        chk("single_busy",  64'(busy), 64'd0);

        // Round robin from pointer 3
        do_reset();
        wb_ready = 1'b1;
        for (int i = 0; i < N; i++) drive(i, i + 1, 64'hA0 + 64'(i));
        tick();
        src_valid = '0;
        for (int c = 0; c < N; c++) begin
            settle();
            $display("txn rr: cycle %0d rd=%0d src=%0d", c + 1, wb_rd, wb_src);
            chk("rr_rd",   64'(wb_rd), 64'(c + 1));
            chk("rr_src",  64'(wb_src), 64'(c));
            chk("rr_data", wb_data, 64'hA0 + 64'(c));
            tick();
        end
        settle();
        chk("rr_cnt",   64'(conflict_cnt), 64'd3);
        chk("rr_empty", 64'(wb_valid), 64'd0);

        // Backpressure with a refill and a later-arriving ALU result
        wb_ready = 1'b0;
        drive(2, 9, 64'h99);
        tick();
        src_valid = '0;
        drive(2, 10, 64'hAA);
        drive(0, 11, 64'hBB);
        for (int c = 0; c < 3; c++) begin
            settle();
            $display("txn stall: cycle %0d rd=%0d ready=%b", c, wb_rd, src_ready);
            chk("bp_rd",    64'(wb_rd), 64'd9);
            chk("bp_src",   64'(wb_src), 64'd2);
            chk("bp_ready", 64'(src_ready[2]), 64'd0);
            tick();
            src_valid[0] = 1'b0;
        end
        wb_ready = 1'b1;
        settle();
        chk("bp_release_rd",    64'(wb_rd), 64'd9);
        chk("bp_release_ready", 64'(src_ready[2]), 64'd1);
        tick();
        src_valid = '0;
        settle();
        $display("txn bp: after release rd=%0d src=%0d", wb_rd, wb_src);
        chk("bp_next_rd", 64'(wb_rd), 64'd11);
        tick();
        settle();
        chk("bp_refill_rd",   64'(wb_rd), 64'd10);
        chk("bp_refill_data", wb_data, 64'hAA);
        tick();

        // Kill
        wb_ready = 1'b0;
        drive(3, 20, 64'h20);
        drive(2, 21, 64'h21);
        tick();
        src_valid = '0;
        kill = 1'b1;
        drive(0, 5, 64'h55);
        settle();
        $display("txn kill: wb_valid=%0d ready=%b", wb_valid, src_ready);
        chk("kill_valid_kept", 64'(wb_valid), 64'd1);
        chk("kill_ready",      64'(src_ready), 64'd0);
        tick();
        kill = 1'b0;
        src_valid = '0;
        settle();
        chk("kill_after_valid", 64'(wb_valid), 64'd0);
        chk("kill_after_busy",  64'(busy), 64'd0);
        tick();

        // rd = 0 drop
        wb_ready = 1'b1;
        drive(1, 0, 64'hFF);
        settle();
        $display("txn rd0: ready=%b", src_ready);
        chk("rd0_ready", 64'(src_ready[1]), 64'd1);
        chk("rd0_valid", 64'(wb_valid), 64'd0);
        tick();
        src_valid = '0;
        settle();
        chk("rd0_after_valid", 64'(wb_valid), 64'd0);
        chk("rd0_after_busy",  64'(busy), 64'd0);
        tick();

        // Sustained throughput with all sources active
        wb_ready = 1'b1;
        tp_cnt = 0;
        for (int i = 0; i < N; i++) begin
            tp_data[i] = 64'h1000 * 64'(i + 1);
            drive(i, i + 1, tp_data[i]);
        end
        for (int c = 0; c < 13; c++) begin
            settle();
            if (c >= 1 && wb_valid) tp_cnt++;
            acc = src_valid & src_ready;
            tick();
            for (int i = 0; i < N; i++) begin
                if (acc[i]) begin
                    tp_data[i] = tp_data[i] + 64'd1;
                    drive(i, i + 1, tp_data[i]);
                end
            end
        end
        src_valid = '0;
        $display("txn throughput: %0d results in 12 cycles", tp_cnt);
        chk("throughput", 64'(tp_cnt), 64'd12);
        for (int c = 0; c < 5; c++) tick();

        // Asynchronous reset during a stall with three full buffers
        wb_ready = 1'b0;
        drive(0, 1, 64'h11);
        drive(1, 2, 64'h22);
        drive(3, 3, 64'h33);
        tick();
        src_valid = '0;
        settle();
        chk("areset_pre_busy", 64'(busy), 64'd1);
        tick();
        settle();
        rstn = 1'b0;
        #1;
        $display("txn async reset: wb_valid=%0d busy=%0d", wb_valid, busy);
        chk("areset_valid", 64'(wb_valid), 64'd0);
        chk("areset_rd",    64'(wb_rd), 64'd0);
        chk("areset_data",  wb_data, 64'd0);
        chk("areset_src",   64'(wb_src), 64'd0);
        chk("areset_busy",  64'(busy), 64'd0);
        chk("areset_ready", 64'(src_ready), 64'hF);
        chk("areset_cnt",   64'(conflict_cnt), 64'd0);
        tick();
        rstn = 1'b1;
        settle();
        chk("areset_after_valid", 64'(wb_valid), 64'd0);
        tick();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
